// File: rtl/cpu_host_loader_if.sv
// rtl/cpu_host_loader_if.sv - host command/response stream bundle for cpu_host_loader
// Purpose: groups the host-side command and response valid/ready streams.
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data  command stream, host -> loader
//   rsp_valid/rsp_ready/rsp_data/rsp_err          response stream, loader -> host
// Modports: master = host side, slave = loader side.
interface cpu_host_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/cpu_host_loader.sv
// rtl/cpu_host_loader.sv - host command engine driving the CPU test/load ports
// Purpose: executes one host command at a time (IMEM/DMEM write, DMEM read,
//   register read, counted RUN) and returns exactly one response per command.
//   Owns the CPU reset: the CPU only leaves reset while a RUN is in progress.
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   host            command/response streams (slave modport)
//   cpu_rst_n       registered active-low CPU reset
//   imem_*          instruction memory write port
//   dmem_*          data memory read/write port (read data 1 cycle after dmem_re)
//   reg_addr/rdata  register-file read port (combinational read)
//   pc_in           CPU program counter
module cpu_host_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int REG_ADDR_W = 5,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_host_loader_if.slave      host,
    output logic                  cpu_rst_n,
    output logic                  imem_we,
    output logic [IA_W-1:0]       imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  dmem_we,
    output logic                  dmem_re,
    output logic [DA_W-1:0]       dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    output logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [31:0]           reg_rdata,
    input  logic [31:0]           pc_in
);

    localparam logic [2:0] OP_IMEM_WR = 3'd0;
    localparam logic [2:0] OP_DMEM_WR = 3'd1;
    localparam logic [2:0] OP_DMEM_RD = 3'd2;
    localparam logic [2:0] OP_REG_RD  = 3'd3;
    localparam logic [2:0] OP_RUN     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_REG_RD,
        S_RUN,
        S_RESP
    } state_t;

    state_t      state;
    logic [31:0] run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            run_cnt        <= '0;
            cpu_rst_n      <= 1'b0;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= '0;
            dmem_we        <= 1'b0;
            dmem_re        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            reg_addr       <= '0;
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            host.rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready comes up one cycle after reset release
                    if (!host.cmd_ready) begin
                        host.cmd_ready <= 1'b1;
                    end else if (host.cmd_valid) begin
                        host.cmd_ready <= 1'b0;
                        host.rsp_data  <= '0;
                        host.rsp_err   <= 1'b0;
                        case (host.cmd_op)
                            OP_IMEM_WR: begin
                                imem_addr  <= host.cmd_addr[IA_W-1:0];
                                imem_wdata <= host.cmd_data;
                                imem_we    <= 1'b1;
                                state      <= S_WRITE;
                            end
                            OP_DMEM_WR: begin
                                dmem_addr  <= host.cmd_addr[DA_W-1:0];
                                dmem_wdata <= host.cmd_data;
                                dmem_we    <= 1'b1;
                                state      <= S_WRITE;
                            end
                            OP_DMEM_RD: begin
                                dmem_addr <= host.cmd_addr[DA_W-1:0];
                                dmem_re   <= 1'b1;
                                state     <= S_RD_REQ;
                            end
                            OP_REG_RD: begin
                                reg_addr <= host.cmd_addr[REG_ADDR_W-1:0];
                                state    <= S_REG_RD;
                            end
                            OP_RUN: begin
                                if (host.cmd_data == 32'd0) begin
                                    host.rsp_valid <= 1'b1;
                                    state          <= S_RESP;
                                end else begin
                                    run_cnt   <= host.cmd_data;
                                    cpu_rst_n <= 1'b1;
                                    state     <= S_RUN;
                                end
                            end
                            default: begin
                                host.rsp_err   <= 1'b1;
                                host.rsp_valid <= 1'b1;
                                state          <= S_RESP;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    imem_we        <= 1'b0;
                    dmem_we        <= 1'b0;
                    host.rsp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_RD_REQ: begin
                    dmem_re <= 1'b0;
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    host.rsp_data  <= dmem_rdata;
                    host.rsp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_REG_RD: begin
                    host.rsp_data  <= reg_rdata;
                    host.rsp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_RUN: begin
                    if (cpu_rst_n) begin
                        // last counted edge: drop reset so the CPU saw exactly N edges
                        if (run_cnt == 32'd1) begin
                            cpu_rst_n <= 1'b0;
                        end
                        run_cnt <= run_cnt - 32'd1;
                    end else begin
                        // the CPU's reset takes hold on this edge, so pc_in still
                        // reflects all N executed edges
                        host.rsp_data  <= pc_in;
                        host.rsp_valid <= 1'b1;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_host_loader.sv
// tb/tb_cpu_host_loader.sv - directed self-checking bench for cpu_host_loader
module tb_cpu_host_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_host_loader_if bus ();

    logic        cpu_rst_n;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic        dmem_re;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [4:0]  reg_addr;
    logic [31:0] reg_rdata;
    logic [31:0] pc;

    cpu_host_loader dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus),
        .cpu_rst_n  (cpu_rst_n),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .reg_addr   (reg_addr),
        .reg_rdata  (reg_rdata),
        .pc_in      (pc)
    );

    // data memory with 1-cycle registered read
    logic [31:0] dmem [0:1023];
    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= dmem[dmem_addr];
    end

    // register file: value encodes its own address
    assign reg_rdata = 32'hA5A5_0000 | {27'd0, reg_addr};

    // straight-line CPU: PC advances one per edge out of (synchronous) reset
    always @(posedge clk) begin
        if (!cpu_rst_n) pc <= 32'd0;
        else            pc <= pc + 32'd1;
    end

    int          imem_pulses = 0;
    int          dmem_we_pulses = 0;
    int          dmem_re_pulses = 0;
    int          run_edges = 0;
    int          run_side = 0;
    logic [9:0]  imem_last_addr = '0;
    logic [31:0] imem_last_data = '0;

    always @(posedge clk) begin
        if (imem_we) begin
            imem_pulses++;
            imem_last_addr = imem_addr;
            imem_last_data = imem_wdata;
        end
        if (dmem_we) dmem_we_pulses++;
        if (dmem_re) dmem_re_pulses++;
        if (cpu_rst_n) begin
            run_edges++;
            if (imem_we || dmem_we || dmem_re) run_side++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                bus.cmd_op    = op;
                bus.cmd_addr  = addr;
                bus.cmd_data  = data;
                bus.cmd_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
                ok = 1'b1;
            end
        end
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    // returns at the negedge where rsp_valid is first seen; lat counts cycles after accept
    task automatic wait_rsp(output int lat);
        bit found;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) found = 1'b1;
        end
        if (!found) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic err, output int lat);
        send_cmd(op, addr, data);
        wait_rsp(lat);
        rdata = bus.rsp_data;
        err   = bus.rsp_err;
        ack_rsp();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          p0, p1, p2, e0, bad;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 16'd0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_we_re", 32'({imem_we, dmem_we, dmem_re}), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // IMEM write
        p0 = imem_pulses;
        do_cmd(3'd0, 16'd3, 32'hDEAD_BEEF, rd, er, lat);
        check("imem_wr_pulses", 32'(imem_pulses - p0), 32'd1);
        check("imem_wr_addr", 32'(imem_last_addr), 32'd3);
        check("imem_wr_data", imem_last_data, 32'hDEAD_BEEF);
        check("imem_wr_rsp", rd, 32'd0);
        check("imem_wr_err", 32'(er), 32'd0);
        check("imem_wr_lat", 32'(lat), 32'd2);
        @(negedge clk);
        check("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);

        // DMEM write then read back, plus upper-address truncation
        do_cmd(3'd1, 16'h0010, 32'h0000_1234, rd, er, lat);
        check("dmem_wr_lat", 32'(lat), 32'd2);
        do_cmd(3'd1, 16'h0411, 32'h0000_CAFE, rd, er, lat);
        p1 = dmem_re_pulses;
        do_cmd(3'd2, 16'h0010, 32'd0, rd, er, lat);
        check("dmem_rd_data", rd, 32'h0000_1234);
        check("dmem_rd_lat", 32'(lat), 32'd3);
        check("dmem_rd_pulses", 32'(dmem_re_pulses - p1), 32'd1);
        do_cmd(3'd2, 16'h0011, 32'd0, rd, er, lat);
        check("dmem_trunc_data", rd, 32'h0000_CAFE);

        // register read with truncated address 0x27 -> 7
        do_cmd(3'd3, 16'h0027, 32'd0, rd, er, lat);
        check("reg_rd_data", rd, 32'hA5A5_0007);
        check("reg_rd_lat", 32'(lat), 32'd2);

        // RUN 5
        e0 = run_edges;
        do_cmd(3'd4, 16'd0, 32'd5, rd, er, lat);
        check("run5_edges", 32'(run_edges - e0), 32'd5);
        check("run5_pc", rd, 32'd5);
        check("run5_lat", 32'(lat), 32'd7);
        check("run5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // RUN 0
        e0 = run_edges;
        do_cmd(3'd4, 16'd0, 32'd0, rd, er, lat);
        check("run0_edges", 32'(run_edges - e0), 32'd0);
        check("run0_data", rd, 32'd0);

        // illegal opcode
        p0 = imem_pulses; p1 = dmem_we_pulses; p2 = dmem_re_pulses; e0 = run_edges;
        do_cmd(3'd6, 16'd5, 32'h1111_1111, rd, er, lat);
        check("illegal_err", 32'(er), 32'd1);
        check("illegal_data", rd, 32'd0);
        check("illegal_side", 32'((imem_pulses - p0) + (dmem_we_pulses - p1) + (dmem_re_pulses - p2) + (run_edges - e0)), 32'd0);

        // back-pressure: response held stable for 10 cycles
        send_cmd(3'd3, 16'd2, 32'd0);
        wait_rsp(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hA5A5_0002 ||
                bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0 || cpu_rst_n !== 1'b0) bad++;
        end
        check("backpressure_stable", 32'(bad), 32'd0);
        check("backpressure_data", bus.rsp_data, 32'hA5A5_0002);
        ack_rsp();

        // no we/re while the CPU was out of reset
        check("run_no_side_effects", 32'(run_side), 32'd0);

        // reset in the middle of RUN 100
        send_cmd(3'd4, 16'd0, 32'd100);
        repeat (20) @(negedge clk);
        check("run100_active", 32'(cpu_rst_n), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || cpu_rst_n !== 1'b0) bad++;
        end
        check("abort_no_rsp", 32'(bad), 32'd0);
        check("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);
        do_cmd(3'd3, 16'd4, 32'd0, rd, er, lat);
        check("post_abort_reg_rd", rd, 32'hA5A5_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
